pill_dose_scheduler: RTL and testbench

//  - Parametrised N-channel dose scheduler; successor to the fixed 3-pill next-pill monitor and taken recorder.
//  - Each channel counts down a programmable interval in seconds, then raises a due flag.
//  - After a grace window, a due dose not acknowledged is counted as missed and the interval restarts.
//  - Fed by the 1 s tick and the shaped buttons; drives the LEDs, 7-seg, LCD and RAM logger.

---
 rtl/pill_sched_pkg.sv | 23 ++
 rtl/pill_channel.sv | 103 ++++++++++
 rtl/pill_dose_scheduler.sv | 108 ++++++++++
 tb/tb_pill_dose_scheduler.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pill_sched_pkg.sv
// Shared encodings and helpers for the pill dose scheduler and its per-channel engine.
package pill_sched_pkg;

   typedef enum logic [1:0] {
      G_STOPPED = 2'd0,
      G_RUNNING = 2'd1,
      G_PAUSED  = 2'd2
   } globalState_t;

   typedef enum logic [1:0] {
      CH_IDLE  = 2'd0,
      CH_COUNT = 2'd1,
      CH_DUE   = 2'd2
   } chState_t;

   localparam int DEFAULT_GRACE = 4;

   // Index/counter width that never collapses to zero bits.
   function automatic int clog2Min1(input int value);
      return (value <= 2) ? 1 : $clog2(value);
   endfunction

endpackage

// File: rtl/pill_channel.sv
// One dose channel: counts the interval down, holds the dose due for a grace window,
// then records a miss and restarts. Acknowledge in DUE reloads the schedule.
module pill_channel
   import pill_sched_pkg::*;
#(
   parameter int CNT_W  = 8,
   parameter int MISS_W = 4,
   parameter int GRACE  = DEFAULT_GRACE
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              tick_en,
   input  logic              load,
   input  logic              ack,
   input  logic [CNT_W-1:0]  interval,
   output logic              due,
   output logic [CNT_W-1:0]  remaining,
   output logic [MISS_W-1:0] missed,
   output logic              miss_pulse,
   output chState_t          dbgState
);

   localparam int GRACE_W = clog2Min1(GRACE + 1);

   chState_t            state, stateNext;
   logic [GRACE_W-1:0]  grace, graceNext;
   logic [CNT_W-1:0]    remNext;
   logic [MISS_W-1:0]   missedNext;
   logic                dueNext, pulseNext;

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= CH_IDLE;
         grace      <= '0;
         remaining  <= '0;
         missed     <= '0;
         due        <= 1'b0;
         miss_pulse <= 1'b0;
      end else begin
         state      <= stateNext;
         grace      <= graceNext;
         remaining  <= remNext;
         missed     <= missedNext;
         due        <= dueNext;
         miss_pulse <= pulseNext;
      end
   end

   // An acknowledge beats a grace expiry arriving on the same clock.
   always_comb begin
      stateNext  = state;
      graceNext  = grace;
      remNext    = remaining;
      missedNext = missed;
      dueNext    = due;
      pulseNext  = 1'b0;
      if (load) begin
         dueNext   = 1'b0;
         graceNext = '0;
         if (interval != '0) begin
            stateNext = CH_COUNT;
            remNext   = interval;
         end else begin
            stateNext = CH_IDLE;
            remNext   = '0;
         end
      end else if (ack && state == CH_DUE) begin
         stateNext = CH_COUNT;
         remNext   = interval;
         dueNext   = 1'b0;
         graceNext = '0;
      end else if (tick_en) begin
         case (state)
            CH_COUNT: begin
               if (remaining <= CNT_W'(1)) begin
                  remNext   = '0;
                  stateNext = CH_DUE;
                  dueNext   = 1'b1;
                  graceNext = GRACE_W'(GRACE);
               end else begin
                  remNext = remaining - CNT_W'(1);
               end
            end
            CH_DUE: begin
               if (grace <= GRACE_W'(1)) begin
                  graceNext = '0;
                  stateNext = CH_COUNT;
                  dueNext   = 1'b0;
                  remNext   = interval;
                  pulseNext = 1'b1;
                  if (missed != {MISS_W{1'b1}}) missedNext = missed + MISS_W'(1);
               end else begin
                  graceNext = grace - GRACE_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

   assign dbgState = state;

endmodule

// File: rtl/pill_dose_scheduler.sv
// N-channel dose scheduler: global run/pause control, interval configuration,
// acknowledge decode and lowest-index miss reporting around per-channel engines.
module pill_dose_scheduler
   import pill_sched_pkg::*;
#(
   parameter int N_PILLS   = 3,
   parameter int CNT_W     = 8,
   parameter int MISS_W    = 4,
   parameter int GRACE     = DEFAULT_GRACE,
   localparam int ID_W     = clog2Min1(N_PILLS)
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      tick,
   input  logic                      start,
   input  logic                      pause,
   input  logic                      cfg_we,
   input  logic [ID_W-1:0]           cfg_id,
   input  logic [CNT_W-1:0]          cfg_interval,
   input  logic                      taken,
   input  logic [ID_W-1:0]           taken_id,
   output logic                      running,
   output logic [N_PILLS-1:0]        due,
   output logic                      alert,
   output logic [N_PILLS*CNT_W-1:0]  remaining,
   output logic [N_PILLS*MISS_W-1:0] missed_cnt,
   output logic                      miss_evt,
   output logic [ID_W-1:0]           miss_id,
   output globalState_t              dbgState,
   output logic [2*N_PILLS-1:0]      dbgChState
);

   globalState_t     state, stateNext;
   logic [CNT_W-1:0] intervalReg [N_PILLS];
   logic [N_PILLS-1:0] ackVec, missPulse;
   chState_t         chState [N_PILLS];
   logic             loadAll, tickEn;

   always_ff @(posedge clk) begin
      if (reset) state <= G_STOPPED;
      else       state <= stateNext;
   end

   // Only a reset returns the scheduler to STOPPED.
   always_comb begin
      stateNext = state;
      case (state)
         G_STOPPED: if (start) stateNext = G_RUNNING;
         G_RUNNING: if (pause) stateNext = G_PAUSED;
         G_PAUSED:  if (start) stateNext = G_RUNNING;
         default:   stateNext = G_STOPPED;
      endcase
   end

   assign running  = (state == G_RUNNING);
   assign loadAll  = (state == G_STOPPED) && start;
   assign tickEn   = running && tick;
   assign dbgState = state;

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < N_PILLS; i++) intervalReg[i] <= '0;
      end else if (state == G_STOPPED && cfg_we) begin
         for (int i = 0; i < N_PILLS; i++)
            if (cfg_id == ID_W'(i)) intervalReg[i] <= cfg_interval;
      end
   end

   always_comb begin
      ackVec = '0;
      for (int i = 0; i < N_PILLS; i++)
         ackVec[i] = taken && (state != G_STOPPED) && (taken_id == ID_W'(i));
   end

   genvar g;
   generate
      for (g = 0; g < N_PILLS; g++) begin : gen_ch
         pill_channel #(
            .CNT_W  (CNT_W),
            .MISS_W (MISS_W),
            .GRACE  (GRACE)
         ) u_ch (
            .clk        (clk),
            .reset      (reset),
            .tick_en    (tickEn),
            .load       (loadAll),
            .ack        (ackVec[g]),
            .interval   (intervalReg[g]),
            .due        (due[g]),
            .remaining  (remaining[g*CNT_W +: CNT_W]),
            .missed     (missed_cnt[g*MISS_W +: MISS_W]),
            .miss_pulse (missPulse[g]),
            .dbgState   (chState[g])
         );
         assign dbgChState[g*2 +: 2] = chState[g];
      end
   endgenerate

   assign alert    = |due;
   assign miss_evt = |missPulse;

   always_comb begin
      miss_id = '0;
      for (int i = N_PILLS - 1; i >= 0; i--)
         if (missPulse[i]) miss_id = ID_W'(i);
   end

endmodule

// File: tb/tb_pill_dose_scheduler.sv
// Bench for pill_dose_scheduler: directed scenarios plus random traffic, every cycle
// checked against an elapsed-time model of the dose schedule.
module tb_pill_dose_scheduler;
   import pill_sched_pkg::*;

   localparam int NP = 3;
   localparam int GR = 2;

   logic        clk, reset, tick, start, pause, cfg_we, taken;
   logic [1:0]  cfg_id, taken_id, miss_id;
   logic [7:0]  cfg_interval;
   logic        running, alert, miss_evt;
   logic [2:0]  due;
   logic [23:0] remaining;
   logic [11:0] missed_cnt;
   globalState_t dbgState;
   logic [5:0]  dbgChState;

   pill_dose_scheduler #(.N_PILLS(NP), .CNT_W(8), .MISS_W(4), .GRACE(GR)) dut (
      .clk(clk), .reset(reset), .tick(tick), .start(start), .pause(pause),
      .cfg_we(cfg_we), .cfg_id(cfg_id), .cfg_interval(cfg_interval),
      .taken(taken), .taken_id(taken_id), .running(running), .due(due),
      .alert(alert), .remaining(remaining), .missed_cnt(missed_cnt),
      .miss_evt(miss_evt), .miss_id(miss_id), .dbgState(dbgState),
      .dbgChState(dbgChState)
   );

   // clock / reset block
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // reference model: each channel tracks ticks elapsed since its schedule anchor
   int  mGs;            // 0 stopped, 1 running, 2 paused
   int  mIntv [NP];
   int  mElapsed [NP];
   int  mMissed [NP];
   bit  mActive [NP];
   bit  mEvt;
   int  mId;

   logic [43:0] expQ[$];
   int nCompared = 0;
   int nMismatch = 0;

   function automatic void modelStep();
      mEvt = 1'b0;
      mId  = 0;
      if (reset) begin
         mGs = 0;
         for (int i = 0; i < NP; i++) begin
            mIntv[i] = 0; mElapsed[i] = 0; mMissed[i] = 0; mActive[i] = 1'b0;
         end
         return;
      end
      if (mGs == 0) begin
         if (start) begin
            for (int i = 0; i < NP; i++) begin
               mActive[i] = (mIntv[i] != 0);
               mElapsed[i] = 0;
            end
            mGs = 1;
         end
         if (cfg_we && int'(cfg_id) < NP) mIntv[cfg_id] = int'(cfg_interval);
      end else begin
         for (int i = 0; i < NP; i++) begin
            if (!mActive[i]) continue;
            if (taken && int'(taken_id) == i && mElapsed[i] >= mIntv[i]) begin
               mElapsed[i] = 0;
            end else if (mGs == 1 && tick) begin
               mElapsed[i]++;
               if (mElapsed[i] == mIntv[i] + GR) begin
                  mElapsed[i] = 0;
                  if (mMissed[i] < 15) mMissed[i]++;
                  if (!mEvt) begin mEvt = 1'b1; mId = i; end
               end
            end
         end
         if (mGs == 1 && pause) mGs = 2;
         else if (mGs == 2 && start) mGs = 1;
      end
   endfunction

   function automatic logic [43:0] modelVector();
      logic [2:0]  d;
      logic [23:0] r;
      logic [11:0] m;
      d = '0; r = '0; m = '0;
      for (int i = 0; i < NP; i++) begin
         d[i] = mActive[i] && (mElapsed[i] >= mIntv[i]);
         if (mActive[i] && !d[i]) r[i*8 +: 8] = 8'(mIntv[i] - mElapsed[i]);
         m[i*4 +: 4] = 4'(mMissed[i]);
      end
      return {(mGs == 1), d, |d, r, m, mEvt, 2'(mId)};
   endfunction

   // scoreboard
   task automatic checkAll(input string tag);
      logic [43:0] obs, expv;
      expQ.push_back(modelVector());
      expv = expQ.pop_front();
      obs  = {running, due, alert, remaining, missed_cnt, miss_evt, miss_id};
      nCompared++;
      assert (obs === expv) else begin
         nMismatch++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      nCompared++;
      assert (obs === expv) else begin
         nMismatch++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   // driver tasks
   task automatic doCycle(input string tag);
      @(posedge clk);
      modelStep();
      #1;
      checkAll(tag);
      tick = 1'b0; start = 1'b0; pause = 1'b0; cfg_we = 1'b0; taken = 1'b0;
   endtask

   task automatic doReset();
      reset = 1'b1;
      doCycle("reset");
      reset = 1'b0;
   endtask

   task automatic doCfg(input logic [1:0] id, input logic [7:0] val);
      cfg_we = 1'b1; cfg_id = id; cfg_interval = val;
      doCycle("cfg");
   endtask

   task automatic doStart();
      start = 1'b1;
      doCycle("start");
   endtask

   task automatic doPause();
      pause = 1'b1;
      doCycle("pause");
   endtask

   task automatic doTicks(input int n);
      for (int k = 0; k < n; k++) begin
         tick = 1'b1;
         doCycle("tick");
      end
   endtask

   task automatic doTaken(input logic [1:0] id);
      taken = 1'b1; taken_id = id;
      doCycle("taken");
   endtask

   initial begin
      reset = 1'b1; tick = 1'b0; start = 1'b0; pause = 1'b0; cfg_we = 1'b0;
      taken = 1'b0; cfg_id = '0; taken_id = '0; cfg_interval = '0;
      doReset();
      doReset();
      checkVal("reset_state", dbgState, G_STOPPED);
      checkVal("reset_alert", alert, 0);

      // scenario 1: ch0=3, ch1 disabled, ch2=5
      doCfg(2'd0, 8'd3); doCfg(2'd1, 8'd0); doCfg(2'd2, 8'd5);
      doStart();
      checkVal("t1_running", dbgState, G_RUNNING);
      checkVal("t1_ch1_idle", dbgChState[3:2], CH_IDLE);
      doTicks(3);
      checkVal("t1_due", due, 3'b001);
      checkVal("t1_alert", alert, 1);
      checkVal("t1_rem1", remaining[15:8], 0);

      // scenario 2: acknowledge the due dose
      doTaken(2'd0);
      checkVal("t2_due0", due[0], 0);
      checkVal("t2_rem0", remaining[7:0], 3);
      checkVal("t2_miss0", missed_cnt[3:0], 0);

      // scenario 3: let ch0 lapse through the grace window
      doTicks(3);
      checkVal("t3_due0", due[0], 1);
      doTicks(2);
      checkVal("t3_evt", miss_evt, 1);
      checkVal("t3_id", miss_id, 0);
      checkVal("t3_miss0", missed_cnt[3:0], 1);
      checkVal("t3_rem0", remaining[7:0], 3);
      doCycle("idle");
      checkVal("t3_evt_drop", miss_evt, 0);

      // scenario 4a: two channels miss together
      doReset();
      doCfg(2'd0, 8'd2); doCfg(2'd2, 8'd2);
      doStart();
      doTicks(4);
      checkVal("t4_evt", miss_evt, 1);
      checkVal("t4_id", miss_id, 0);
      checkVal("t4_miss0", missed_cnt[3:0], 1);
      checkVal("t4_miss2", missed_cnt[11:8], 1);
      doCycle("idle");
      checkVal("t4_one_evt", miss_evt, 0);

      // scenario 4b: taken on the expiring clock wins for ch0
      doReset();
      doCfg(2'd0, 8'd2); doCfg(2'd2, 8'd2);
      doStart();
      doTicks(3);
      tick = 1'b1;
      doTaken(2'd0);
      checkVal("t4b_miss0", missed_cnt[3:0], 0);
      checkVal("t4b_miss2", missed_cnt[11:8], 1);
      checkVal("t4b_id", miss_id, 2);
      checkVal("t4b_rem0", remaining[7:0], 2);

      // scenario 5: pause freezes, config ignored, resume without reload
      doReset();
      doCfg(2'd0, 8'd5);
      doStart();
      doTicks(1);
      doPause();
      doTicks(10);
      checkVal("t5_frozen", remaining[7:0], 4);
      doCfg(2'd0, 8'd9);
      doTaken(2'd0);
      checkVal("t5_cfg_ign", remaining[7:0], 4);
      doStart();
      doTicks(1);
      checkVal("t5_resume", remaining[7:0], 3);

      // scenario 6: saturation, then reset mid-count
      doReset();
      doCfg(2'd0, 8'd1);
      doStart();
      doTicks(48);
      checkVal("t6_sat16", missed_cnt[3:0], 15);
      doTicks(3);
      checkVal("t6_sat17", missed_cnt[3:0], 15);
      checkVal("t6_evt17", miss_evt, 1);
      doTicks(1);
      doReset();
      checkVal("t6_rst_state", dbgState, G_STOPPED);
      checkVal("t6_rst_out", {running, due, alert, remaining, missed_cnt, miss_evt}, 0);

      // random traffic
      doReset();
      for (int i = 0; i < 3; i++) doCfg(2'(i), 8'($urandom_range(0, 6)));
      doCfg(2'd3, 8'd7);
      doStart();
      for (int n = 0; n < 400; n++) begin
         tick         = ($urandom_range(0, 1) == 1);
         taken        = ($urandom_range(0, 4) == 0);
         taken_id     = 2'($urandom_range(0, 3));
         pause        = ($urandom_range(0, 29) == 0);
         start        = ($urandom_range(0, 19) == 0);
         cfg_we       = ($urandom_range(0, 19) == 0);
         cfg_id       = 2'($urandom_range(0, 3));
         cfg_interval = 8'($urandom_range(0, 255));
         doCycle("rand");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
      $finish;
   end

endmodule
